// File: rtl/q_env_step.sv
// Grid-world environment with epsilon-greedy action selection; emits one
// (row, col, action, next_row, next_col, reward) tuple per step to the Q-learning update stage.
module q_env_step #(
    parameter int         ROWS        = 5,
    parameter int         COLS        = 5,
    parameter int         ACTIONS     = 4,
    parameter int         ADDR_WIDTH  = 7,
    parameter int         DATA_WIDTH  = 8,
    parameter logic [7:0] EPSILON     = 8'd26,
    parameter logic [7:0] LFSR_SEED   = 8'hA5,
    parameter logic [7:0] GOAL_REWARD = 8'd10,
    parameter logic [7:0] STEP_REWARD = 8'd0,
    parameter logic [7:0] WALL_REWARD = 8'hFF,
    parameter logic [7:0] MAX_STEPS   = 8'd255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    output logic [ADDR_WIDTH-1:0] q_rd_addr,
    input  logic [DATA_WIDTH-1:0] q_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2:0]            row,
    output logic [2:0]            col,
    output logic [1:0]            action,
    output logic [2:0]            next_row,
    output logic [2:0]            next_col,
    output logic [7:0]            reward,
    output logic [7:0]            step_count,
    output logic [15:0]           episode_count,
    output logic                  busy,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_LAST    = 3'd2,
        S_DECIDE  = 3'd3,
        S_ISSUE   = 3'd4,
        S_ADVANCE = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            k_q, k_d;
    logic [DATA_WIDTH-1:0] q_val_q [4];
    logic [7:0]            lfsr_q;
    logic [2:0]            row_q, col_q, nrow_q, ncol_q;
    logic [1:0]            act_q;
    logic [7:0]            rew_q;
    logic                  goal_q;
    logic [7:0]            step_q;
    logic [15:0]           ep_q;

    logic [1:0]            best_a;
    logic [DATA_WIDTH-1:0] best_v;
    logic [1:0]            dec_act;
    logic [2:0]            dec_row, dec_col;
    logic                  blocked, dec_goal;
    logic [7:0]            dec_rew;
    logic [7:0]            step_inc;

    // Handshake: the tuple transfers on the rising edge where out_valid && out_ready;
    // out_valid is high only in ISSUE, so the tuple registers cannot move while it waits.
    assign out_valid     = (state_q == S_ISSUE);
    assign busy          = (state_q != S_IDLE);
    assign dbg_state     = state_q;
    assign row           = row_q;
    assign col           = col_q;
    assign action        = act_q;
    assign next_row      = nrow_q;
    assign next_col      = ncol_q;
    assign reward        = rew_q;
    assign step_count    = step_q;
    assign episode_count = ep_q;
    assign step_inc      = step_q + 8'd1;

    always_comb begin
        q_rd_addr = '0;
        if (state_q == S_READ) begin
            q_rd_addr = ADDR_WIDTH'((int'(row_q) * COLS + int'(col_q)) * ACTIONS + int'(k_q));
        end
    end

    // Action choice and move outcome; only sampled into the tuple registers in DECIDE.
    always_comb begin
        best_a = 2'd0;
        best_v = q_val_q[0];
        for (int i = 1; i < 4; i++) begin
            if (q_val_q[i] > best_v) begin
                best_v = q_val_q[i];
                best_a = 2'(i);
            end
        end
        dec_act = (lfsr_q < EPSILON) ? lfsr_q[1:0] : best_a;
        dec_row = row_q;
        dec_col = col_q;
        blocked = 1'b0;
        case (dec_act)
            2'd0: if (row_q == 3'd0) blocked = 1'b1; else dec_row = row_q - 3'd1;
            2'd1: if (row_q == 3'(ROWS - 1)) blocked = 1'b1; else dec_row = row_q + 3'd1;
            2'd2: if (col_q == 3'd0) blocked = 1'b1; else dec_col = col_q - 3'd1;
            default: if (col_q == 3'(COLS - 1)) blocked = 1'b1; else dec_col = col_q + 3'd1;
        endcase
        dec_goal = !blocked && (dec_row == 3'(ROWS - 1)) && (dec_col == 3'(COLS - 1));
        dec_rew  = blocked ? WALL_REWARD : (dec_goal ? GOAL_REWARD : STEP_REWARD);
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_READ;
                    k_d     = 2'd0;
                end
            end
            S_READ: begin
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) state_d = S_LAST;
            end
            S_LAST:   state_d = S_DECIDE;
            S_DECIDE: state_d = S_ISSUE;
            S_ISSUE:  if (out_ready) state_d = S_ADVANCE;
            S_ADVANCE: begin
                k_d     = 2'd0;
                state_d = run ? S_READ : S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            k_q     <= 2'd0;
            lfsr_q  <= LFSR_SEED;
            for (int i = 0; i < 4; i++) q_val_q[i] <= '0;
            row_q   <= 3'd0;
            col_q   <= 3'd0;
            nrow_q  <= 3'd0;
            ncol_q  <= 3'd0;
            act_q   <= 2'd0;
            rew_q   <= 8'd0;
            goal_q  <= 1'b0;
            step_q  <= 8'd0;
            ep_q    <= 16'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            lfsr_q  <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            // Read data lags the address by one cycle, so READ k captures entry k-1.
            if (state_q == S_READ && k_q != 2'd0) q_val_q[k_q - 2'd1] <= q_rd_data;
            if (state_q == S_LAST) q_val_q[3] <= q_rd_data;
            if (state_q == S_DECIDE) begin
                act_q  <= dec_act;
                nrow_q <= dec_row;
                ncol_q <= dec_col;
                rew_q  <= dec_rew;
                goal_q <= dec_goal;
            end
            if (state_q == S_ADVANCE) begin
                if (goal_q || step_inc == MAX_STEPS) begin
                    row_q  <= 3'd0;
                    col_q  <= 3'd0;
                    step_q <= 8'd0;
                    ep_q   <= ep_q + 16'd1;
                end else begin
                    row_q  <= nrow_q;
                    col_q  <= ncol_q;
                    step_q <= step_inc;
                end
            end
        end
    end

endmodule
